dm_bytelane: RTL and testbench
==============================

// Module: dm_bytelane
// PURPOSE
//  Parametrised data memory for the single-cycle MIPS32 datapath. Supports
//  byte/half/word stores via byte-lane enables and byte/half/word loads with
//  sign or zero extension. Read path is selectable combinational or registered.
//  Flags misaligned and illegal accesses and suppresses their writes.
//  Sits between the ALU address output and the write-back mux.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  REG_READ    0   0: combinational read; 1: registered read, 1-cycle latency
//  INIT_ZERO   1   1: all words zeroed at simulation start (not by reset)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  addr       in   ADDR_WIDTH+2  byte address; [1:0] selects the lane
//  din        in   32            store data, right-aligned (lane 0 = din[7:0])
//  mem_wr     in   1             store request this cycle
//  mem_rd     in   1             load request this cycle
//  size       in   2             00 byte, 01 half, 10 word, 11 illegal
//  sign_ext   in   1             1: sign-extend sub-word loads; 0: zero-extend
//  dout       out  32            load data, extended per size/sign_ext
//  dout_valid out  1             load data valid (see latency)
//  misalign   out  1             current access is misaligned or illegal (comb.)
//  err_sticky out  1             set by any flagged access; cleared only by reset
// BEHAVIOUR
//  - Word index = addr[ADDR_WIDTH+1:2]; lane = addr[1:0].
//  - misalign = (mem_rd|mem_wr) & ((size==01 & addr[0]) | (size==10 & addr[1:0]!=0)
//    | size==11).
//  - Store: at posedge clk, if mem_wr & !misalign, write only the enabled bytes:
//    byte -> lane addr[1:0] gets din[7:0]; half -> lanes {addr[1],0}+1..0 get
//    din[15:0]; word -> all lanes get din. Other bytes are unchanged.
//    A flagged store writes nothing.
//  - Load: select byte/half at the lane, then extend to 32 bits using sign_ext.
//    A word load ignores sign_ext. A flagged load returns 32'h0.
//  - REG_READ=0: dout is combinational from the current array contents.
//    dout_valid = mem_rd & !misalign. A store reaches dout only after its
//    write edge.
//  - REG_READ=1: at posedge, dout <= extended data and dout_valid <= mem_rd &
//    !misalign. When mem_rd is 0, dout holds its value and dout_valid drops
//    to 0. Same-cycle rd+wr to the same word returns OLD data (read-before-write).
//  - err_sticky: at posedge, set if misalign=1; stays set until rst_n=0.
//  - Reset (rst_n=0, asynchronous, any time): dout=0, dout_valid=0,
//    err_sticky=0. Memory contents are NOT cleared. Writes are blocked while
//    rst_n=0. Normal operation resumes on the first posedge after release.
//  - Out-of-range addresses cannot occur (the address is exactly sized).
//    Word index wraps naturally.
//  - mem_rd and mem_wr may both be 1 in the same cycle. The two are
//    independent apart from the ordering stated above.
// TESTING
//  1. sw 32'hDEADBEEF @0x10; lw @0x10 -> dout=32'hDEADBEEF, misalign=0.
//  2. Word @0x20=32'h11223344; sb 8'hAA @0x21 -> lw @0x20 = 32'h1122AA44.
//  3. Word @0x30=32'h8000F0FF; lb @0x30 sign_ext=1 -> 32'hFFFFFFFF;
//     lbu @0x31 -> 32'h000000F0; lh @0x32 -> 32'hFFFF8000.
//  4. sw @0x42, then sh @0x41, then size=11 -> misalign=1, memory at 0x40
//     unchanged, err_sticky=1 after the edge.
//  5. REG_READ=1: lw @0x50 with sw 32'h5 @0x50 in the same cycle -> next cycle
//     dout = old value, dout_valid=1. A lw the following cycle returns 32'h5.
//  6. Assert rst_n=0 mid-load -> dout=0, dout_valid=0, err_sticky=0
//     immediately. Memory data is preserved across the reset.

Source files
------------

// File: rtl/dm_bytelane_if.sv
// rtl/dm_bytelane_if.sv - load/store bus between the datapath and the byte-lane data memory
interface dm_bytelane_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH+1:0] addr;
  logic [31:0]           din;
  logic                  mem_wr;
  logic                  mem_rd;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  misalign;
  logic                  err_sticky;

  modport master (
    output addr, din, mem_wr, mem_rd, size, sign_ext,
    input  dout, dout_valid, misalign, err_sticky
  );

  modport slave (
    input  addr, din, mem_wr, mem_rd, size, sign_ext,
    output dout, dout_valid, misalign, err_sticky
  );
endinterface

// File: rtl/dm_bytelane.sv
// rtl/dm_bytelane.sv - MIPS32 data memory with byte/half/word lanes, load extension and access checking
module dm_bytelane #(
  parameter int ADDR_WIDTH = 10,
  parameter bit REG_READ   = 1'b0,
  parameter bit INIT_ZERO  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  dm_bytelane_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Start-of-simulation contents only; reset deliberately leaves the array alone.
  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic                  bad_access;
  logic                  misalign;
  logic                  rd_ok;
  logic                  we;
  logic [31:0]           word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_data;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  err_q;

  assign idx  = bus.addr[ADDR_WIDTH+1:2];
  assign lane = bus.addr[1:0];

  assign bad_access = (bus.size == 2'b01 && lane[0]) ||
                      (bus.size == 2'b10 && lane != 2'b00) ||
                      (bus.size == 2'b11);
  assign misalign = (bus.mem_rd | bus.mem_wr) & bad_access;
  assign rd_ok    = bus.mem_rd & ~misalign;
  assign we       = bus.mem_wr & ~misalign & rst_n;

  assign word    = mem[idx];
  assign rd_byte = word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = 32'h0;
    if (!misalign) begin
      case (bus.size)
        2'b00:   ld_data = {{24{bus.sign_ext & rd_byte[7]}}, rd_byte};
        2'b01:   ld_data = {{16{bus.sign_ext & rd_half[15]}}, rd_half};
        2'b10:   ld_data = word;
        default: ld_data = 32'h0;
      endcase
    end
  end

  // Replicate store data across lanes so each byte enable just picks its own slice.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.din;
    case (bus.size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.din[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = bus.din;
      end
      default: begin
        be    = 4'b0000;
        wdata = bus.din;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (misalign) err_q <= 1'b1;
  end

  assign bus.misalign   = misalign;
  assign bus.err_sticky = err_q;

  generate
    if (REG_READ) begin : g_reg_read
      logic [31:0] dout_q;
      logic        valid_q;

      // Sampling the array at the edge yields pre-write data for a same-cycle store.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= 32'h0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (bus.mem_rd) dout_q <= ld_data;
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = valid_q;
    end else begin : g_comb_read
      assign bus.dout       = rst_n ? ld_data : 32'h0;
      assign bus.dout_valid = rst_n & rd_ok;
    end
  endgenerate
endmodule

// File: tb/tb_dm_bytelane.sv
// tb/tb_dm_bytelane.sv - random and directed checks of dm_bytelane, combinational and registered read variants
module tb_dm_bytelane;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_bytelane_if #(.ADDR_WIDTH(AW)) if_c ();
  dm_bytelane_if #(.ADDR_WIDTH(AW)) if_r ();

  dm_bytelane #(.ADDR_WIDTH(AW), .REG_READ(1'b0), .INIT_ZERO(1'b1)) u_comb (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  dm_bytelane #(.ADDR_WIDTH(AW), .REG_READ(1'b1), .INIT_ZERO(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(if_r.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mb [256];
  logic [31:0] exp_rdout;
  logic        exp_rvalid;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_mis(input logic acc, input logic [7:0] a, input logic [1:0] sz);
    return acc && (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] sz, input logic se);
    logic [7:0]  b;
    logic [15:0] h;
    if (model_mis(1'b1, a, sz)) return 32'h0;
    case (sz)
      2'd0: begin
        b = mb[a];
        return se ? int'($signed(b)) : {24'h0, b};
      end
      2'd1: begin
        h = {mb[a+1], mb[a]};
        return se ? int'($signed(h)) : {16'h0, h};
      end
      default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endcase
  endfunction

  task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    for (int k = 0; k < n; k++) mb[8'(a + k)] = d[8*k +: 8];
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] d, input logic wr, input logic rd,
                       input logic [1:0] sz, input logic se);
    if_c.addr = a; if_c.din = d; if_c.mem_wr = wr; if_c.mem_rd = rd; if_c.size = sz; if_c.sign_ext = se;
    if_r.addr = a; if_r.din = d; if_r.mem_wr = wr; if_r.mem_rd = rd; if_r.size = sz; if_r.sign_ext = se;
  endtask

  task automatic step(input logic [7:0] a, input logic [31:0] d, input logic wr, input logic rd,
                      input logic [1:0] sz, input logic se);
    logic        mis;
    logic [31:0] ld;
    drive(a, d, wr, rd, sz, se);
    mis = model_mis(wr | rd, a, sz);
    ld  = model_load(a, sz, se);
    #2;
    check("misalign_c", {31'h0, if_c.misalign}, {31'h0, mis});
    check("misalign_r", {31'h0, if_r.misalign}, {31'h0, mis});
    check("valid_c", {31'h0, if_c.dout_valid}, {31'h0, rd & ~mis});
    if (rd) check("dout_c", if_c.dout, ld);
    if (rd) exp_rdout = ld;
    exp_rvalid = rd & ~mis;
    if (mis) exp_err = 1'b1;
    @(posedge clk);
    #1;
    if (wr && !mis) model_store(a, d, sz);
    check("dout_r", if_r.dout, exp_rdout);
    check("valid_r", {31'h0, if_r.dout_valid}, {31'h0, exp_rvalid});
    check("err_c", {31'h0, if_c.err_sticky}, {31'h0, exp_err});
    check("err_r", {31'h0, if_r.err_sticky}, {31'h0, exp_err});
  endtask

  task automatic check_reset_outputs();
    check("rst_dout_c", if_c.dout, 32'h0);
    check("rst_dout_r", if_r.dout, 32'h0);
    check("rst_valid_c", {31'h0, if_c.dout_valid}, 32'h0);
    check("rst_valid_r", {31'h0, if_r.dout_valid}, 32'h0);
    check("rst_err_c", {31'h0, if_c.err_sticky}, 32'h0);
    check("rst_err_r", {31'h0, if_r.err_sticky}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    exp_rdout = 32'h0; exp_rvalid = 1'b0; exp_err = 1'b0;
    drive(8'h00, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    #3;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unwritten memory reads as zero
    step(8'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(8'h10, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    step(8'h20, 32'h11223344, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h21, 32'h000000AA, 1'b1, 1'b0, 2'b00, 1'b0);
    step(8'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    step(8'h30, 32'h8000F0FF, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h30, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1);
    step(8'h31, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    step(8'h32, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1);
    step(8'h32, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
    step(8'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b1);

    step(8'h40, 32'h01020304, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h42, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h41, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b01, 1'b0);
    step(8'h40, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b11, 1'b0);
    step(8'h40, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    // Same-cycle load and store to one word: registered path sees old data
    step(8'h50, 32'h0BADF00D, 1'b1, 1'b0, 2'b10, 1'b0);
    step(8'h50, 32'h00000005, 1'b1, 1'b1, 2'b10, 1'b0);
    step(8'h50, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(8'h50, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);

    // Asynchronous reset in the middle of a load; writes blocked while held
    step(8'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    drive(8'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_rdout = 32'h0; exp_rvalid = 1'b0; exp_err = 1'b0;
    drive(8'h10, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 1'b0);
    @(posedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    step(8'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(8'h20, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);

    for (int n = 0; n < 600; n++) begin
      step(8'($urandom), $urandom, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
